// File: rtl/chacha20_pkg.sv
// Shared widths and FSM encoding for the ChaCha20 keystream consumer.
package chacha20_pkg;

  localparam int unsigned KEY_W   = 256;
  localparam int unsigned NONCE_W = 96;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned BLK_W   = 512;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StStream,
    StErr
  } state_e;

endpackage

// File: rtl/chacha20_stream_xor.sv
// Requests ChaCha20 keystream blocks from the core, buffers each one and XORs it
// word by word onto a 32-bit valid/ready stream (encrypt and decrypt are identical).
module chacha20_stream_xor
  import chacha20_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KEY_W-1:0]   key,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [CNT_W-1:0]   init_count,
  output logic               busy,
  output logic               err,
  output logic [KEY_W-1:0]   ks_key,
  output logic [NONCE_W-1:0] ks_nonce,
  output logic [CNT_W-1:0]   ks_count,
  output logic               ks_req,
  input  logic               ks_valid,
  input  logic [BLK_W-1:0]   ks_block,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WORDS_PER_BLOCK - 1);

  // Word 0 of the block sits in the top 32 bits, so index i selects bit (15-i)*32.
  function automatic logic [WORD_W-1:0] ks_word(input logic [BLK_W-1:0] blk,
                                                input logic [IDX_W-1:0] idx);
    return blk[{~idx, 5'd0} +: WORD_W];
  endfunction

  state_e              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [NONCE_W-1:0]  nonce_q, nonce_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BLK_W-1:0]    buf_q, buf_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                in_hs;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    nonce_d     = nonce_q;
    count_d     = count_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    done_d      = done_q;
    err_d       = err_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    ks_req      = 1'b0;
    in_ready    = 1'b0;
    in_hs       = 1'b0;

    // The output register drains independently of the state, so a pending
    // word still completes after entering FETCH, ERR or IDLE.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      StIdle, StErr: begin
        if (start) begin
          key_d   = key;
          nonce_d = nonce;
          count_d = init_count;
          err_d   = 1'b0;
          idx_d   = '0;
          done_d  = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        ks_req = 1'b1;
        if (ks_valid) begin
          buf_d   = ks_block;
          state_d = StStream;
        end
      end
      StStream: begin
        if (done_q) begin
          // Final word accepted; stay busy until it leaves the output register.
          if (!out_valid_q || out_ready) begin
            done_d  = 1'b0;
            state_d = StIdle;
          end
        end else begin
          in_ready = !out_valid_q || out_ready;
          in_hs    = in_valid && in_ready;
          if (in_hs) begin
            out_data_d  = in_data ^ ks_word(buf_q, idx_q);
            out_valid_d = 1'b1;
            out_last_d  = in_last;
            idx_d       = idx_q + 1'b1;
            if (in_last) begin
              done_d = 1'b1;
            end else if (idx_q == LastIdx) begin
              if (count_q == '1) begin
                err_d   = 1'b1;
                state_d = StErr;
              end else begin
                count_d = count_q + 1'b1;
                state_d = StFetch;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      key_q       <= '0;
      nonce_q     <= '0;
      count_q     <= '0;
      buf_q       <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      count_q     <= count_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign err       = err_q;
  assign ks_key    = key_q;
  assign ks_nonce  = nonce_q;
  assign ks_count  = count_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_chacha20_stream_xor.sv
// Bench for chacha20_stream_xor: a behavioural ChaCha20 core answers block requests and a
// plain-arithmetic reference model predicts the XORed output stream.
module tb_chacha20_stream_xor;
  import chacha20_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  init_count;
  logic         busy, err, ks_req, ks_valid, in_ready, out_valid, out_last;
  logic [255:0] ks_key;
  logic [95:0]  ks_nonce;
  logic [31:0]  ks_count, in_data, out_data;
  logic [511:0] ks_block;
  logic         in_valid, in_last, out_ready;

  logic         core_v, stray_v;
  logic [511:0] core_blk, stray_blk;
  assign ks_valid = core_v | stray_v;
  assign ks_block = stray_v ? stray_blk : core_blk;

  chacha20_stream_xor dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .nonce     (nonce),
    .init_count(init_count),
    .busy      (busy),
    .err       (err),
    .ks_key    (ks_key),
    .ks_nonce  (ks_nonce),
    .ks_count  (ks_count),
    .ks_req    (ks_req),
    .ks_valid  (ks_valid),
    .ks_block  (ks_block),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  int          n_checks;
  int          n_fail;
  logic [32:0] out_q[$];
  logic [32:0] exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] pt_words[$];
  logic [31:0] ct_words[$];
  bit          bp_en;

  // ---------------- reference ChaCha20 (RFC 8439 block function) ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_block(input logic [255:0] k, input logic [95:0] n,
                                                input logic [31:0] c);
    logic [31:0]  s[16];
    logic [31:0]  x[16];
    logic [511:0] blk;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = bswap(k[255-32*i -: 32]);
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = bswap(n[95-32*i -: 32]);
    x = s;
    for (int r = 0; r < 10; r++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = bswap(x[i] + s[i]);
    return blk;
  endfunction

  // Expected stream: word i uses block init+i/16, stream-order word i%16.
  task automatic build_exp(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c0,
                           input logic [31:0] msg[$], input int nw, input bit last_on_final);
    logic [511:0] blk;
    exp_q.delete();
    for (int i = 0; i < nw; i++) begin
      if (i % 16 == 0) blk = chacha_block(k, n, c0 + 32'(i / 16));
      exp_q.push_back({last_on_final && (i == msg.size() - 1),
                       msg[i] ^ blk[511-32*(i%16) -: 32]});
    end
  endtask

  // ---------------- behavioural keystream core ----------------
  initial begin
    int unsigned lat;
    logic [255:0] k;
    logic [95:0]  n;
    logic [31:0]  c;
    core_v = 1'b0;
    core_blk = '0;
    forever begin
      @(posedge clk); #1;
      if (ks_req && rst) begin
        k = ks_key; n = ks_nonce; c = ks_count;
        req_log.push_back(c);
        lat = $urandom_range(1, 4);
        repeat (lat) @(posedge clk);
        #1;
        core_blk = chacha_block(k, n, c);
        core_v = 1'b1;
        @(posedge clk); #1;
        core_v = 1'b0;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output collector plus continuous protocol checks.
  initial begin
    bit          edge_rst;
    bit          stalled;
    logic [31:0] held_d;
    logic        held_l;
    stalled = 1'b0;
    forever begin
      @(posedge clk);
      edge_rst = rst;
      @(negedge clk);
      if (edge_rst && rst && stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                   out_valid, out_data, out_last, held_d, held_l);
        end
      end
      stalled = rst && out_valid && !out_ready;
      held_d  = out_data;
      held_l  = out_last;
      if (rst && out_valid && out_ready) out_q.push_back({out_last, out_data});
      if (rst && ks_req) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL fetch_in_ready: got in_ready=%b required 0 while ks_req", in_ready);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    out_q.delete();
    req_log.delete();
  endtask

  task automatic do_start(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    start = 1'b1; key = k; nonce = n; init_count = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive(input logic [31:0] w[$], input bit last_on_final, input int max_words,
                       input int budget, output int accepted);
    bit ok;
    int waited;
    int nw;
    accepted = 0;
    nw = (max_words < w.size()) ? max_words : w.size();
    for (int i = 0; i < nw; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_data  = w[i];
      in_last  = last_on_final && (i == w.size() - 1);
      in_valid = 1'b1;
      waited   = 0;
      do begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
        waited++;
      end while (!ok && waited < budget);
      if (!ok) break;
      accepted++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [95:0] rand96();
    logic [95:0] v;
    for (int i = 0; i < 3; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [5:0] flags;
    apply_reset();
    @(negedge clk);
    flags = {busy, err, ks_req, in_ready, out_valid, out_last};
    n_checks++;
    if (flags !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000000", flags);
    end
    n_checks++;
    if (out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_data: got %h required 0", out_data);
    end
    n_checks++;
    if (ks_count !== 32'h0) begin
      n_fail++; $display("FAIL reset_ks_count: got %h required 0", ks_count);
    end
    n_checks++;
    if (ks_key !== 256'h0 || ks_nonce !== 96'h0) begin
      n_fail++; $display("FAIL reset_key_nonce: got %h %h required 0", ks_key, ks_nonce);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rfc();
    string       pt_s;
    logic [7:0]  b;
    logic [31:0] w;
    int          acc;
    bit          ok;
    pt_s = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
    pt_words.delete();
    for (int i = 0; i < (pt_s.len() + 3) / 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = (4 * i + j < pt_s.len()) ? pt_s[4*i+j] : 8'h00;
        w[31-8*j -: 8] = b;
      end
      pt_words.push_back(w);
    end
    apply_reset();
    do_start(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
             96'h000000000000004a00000000, 32'd1);
    drive(pt_words, 1'b1, pt_words.size(), 100, acc);
    wait_idle(100, ok);
    build_exp(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              96'h000000000000004a00000000, 32'd1, pt_words, pt_words.size(), 1'b1);
    n_checks++;
    if (acc != pt_words.size() || !ok) begin
      n_fail++; $display("FAIL rfc_accept: got %0d words idle=%b required %0d idle=1",
                         acc, ok, pt_words.size());
    end
    n_checks++;
    if (out_q.size() == 0 || out_q[0][31:0] !== 32'h6e2e359a) begin
      n_fail++; $display("FAIL rfc_first_word: got %h required 6e2e359a",
                         (out_q.size() > 0) ? out_q[0][31:0] : 32'hx);
    end
    n_checks++;
    if (out_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rfc_len: got %0d required %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rfc_word%0d: got %h required %h", i, out_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (req_log.size() != 2 || req_log[0] !== 32'd1 || req_log[1] !== 32'd2) begin
      n_fail++; $display("FAIL rfc_ks_count_seq: got %0d requests required 1,2", req_log.size());
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL rfc_err: got %b required 0", err);
    end
    ct_words.delete();
    foreach (out_q[i]) ct_words.push_back(out_q[i][31:0]);
  endtask

  task automatic test_round_trip();
    int acc;
    bit ok;
    apply_reset();
    do_start(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
             96'h000000000000004a00000000, 32'd1);
    drive(ct_words, 1'b1, ct_words.size(), 100, acc);
    wait_idle(100, ok);
    n_checks++;
    if (out_q.size() != pt_words.size() || !ok) begin
      n_fail++; $display("FAIL rt_len: got %0d idle=%b required %0d idle=1",
                         out_q.size(), ok, pt_words.size());
    end
    for (int i = 0; i < out_q.size() && i < pt_words.size(); i++) begin
      n_checks++;
      if (out_q[i] !== {i == pt_words.size() - 1, pt_words[i]}) begin
        n_fail++; $display("FAIL rt_word%0d: got %h required %h", i, out_q[i], pt_words[i]);
      end
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL rt_err: got %b required 0", err);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] k;
    logic [95:0]  n;
    logic [31:0]  c0;
    logic [31:0]  msg[$];
    int           acc;
    bit           ok;
    k = rand256(); n = rand96(); c0 = $urandom_range(0, 1 << 20);
    for (int i = 0; i < 40; i++) msg.push_back($urandom);
    apply_reset();
    bp_en = 1'b1;
    do_start(k, n, c0);
    drive(msg, 1'b1, 40, 200, acc);
    wait_idle(200, ok);
    bp_en = 1'b0;
    build_exp(k, n, c0, msg, 40, 1'b1);
    n_checks++;
    if (out_q.size() != exp_q.size() || !ok) begin
      n_fail++; $display("FAIL bp_len: got %0d idle=%b required %0d idle=1",
                         out_q.size(), ok, exp_q.size());
    end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_word%0d: got %h required %h", i, out_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (req_log.size() != 3 || req_log[0] !== c0 || req_log[2] !== c0 + 32'd2) begin
      n_fail++; $display("FAIL bp_requests: got %0d requests required 3 from %h",
                         req_log.size(), c0);
    end
  endtask

  task automatic test_counter_limit();
    logic [255:0] k;
    logic [95:0]  n;
    logic [31:0]  msg[$];
    int           acc;
    bit           ok;
    k = rand256(); n = rand96();
    for (int i = 0; i < 20; i++) msg.push_back($urandom);
    apply_reset();
    do_start(k, n, 32'hFFFFFFFF);
    drive(msg, 1'b0, 20, 40, acc);
    build_exp(k, n, 32'hFFFFFFFF, msg, 16, 1'b0);
    @(negedge clk);
    n_checks++;
    if (acc != 16) begin
      n_fail++; $display("FAIL lim_accepted: got %0d required 16", acc);
    end
    n_checks++;
    if (out_q.size() != 16) begin
      n_fail++; $display("FAIL lim_out_count: got %0d required 16", out_q.size());
    end
    for (int i = 0; i < out_q.size() && i < 16; i++) begin
      n_checks++;
      if (out_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL lim_word%0d: got %h required %h", i, out_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || dut.state_q !== StErr) begin
      n_fail++; $display("FAIL lim_err_state: got err=%b in_ready=%b busy=%b st=%0d required 1 0 1 ERR",
                         err, in_ready, busy, dut.state_q);
    end
    n_checks++;
    if (req_log.size() != 1 || ks_req !== 1'b0) begin
      n_fail++; $display("FAIL lim_requests: got %0d ks_req=%b required 1 request, ks_req=0",
                         req_log.size(), ks_req);
    end
    @(posedge clk); #1;
    do_start(k, n, 32'd5);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || ks_count !== 32'd5) begin
      n_fail++; $display("FAIL lim_restart: got err=%b cnt=%h required err=0 cnt=5", err, ks_count);
    end
    // Let the outstanding block arrive so it cannot land in a later test.
    for (int i = 0; i < 20 && ks_req; i++) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_stream();
    logic [31:0] msg[$];
    logic [5:0]  flags;
    int          acc;
    for (int i = 0; i < 20; i++) msg.push_back($urandom);
    apply_reset();
    do_start(rand256(), rand96(), 32'd7);
    drive(msg, 1'b0, 7, 100, acc);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    stray_blk = {16{32'hA5A55A5A}};
    stray_v = 1'b1;
    @(negedge clk);
    flags = {busy, err, ks_req, in_ready, out_valid, out_last};
    n_checks++;
    if (acc != 7 || flags !== 6'b0 || out_data !== 32'h0 || ks_count !== 32'h0 ||
        ks_key !== 256'h0 || ks_nonce !== 96'h0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got acc=%0d flags=%b d=%h cnt=%h required 7 0 0 0",
                         acc, flags, out_data, ks_count);
    end
    @(posedge clk); #1;
    stray_v = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== StIdle || busy !== 1'b0) begin
      n_fail++; $display("FAIL stray_state: got st=%0d busy=%b required IDLE 0", dut.state_q, busy);
    end
    n_checks++;
    if (dut.buf_q !== 512'h0) begin
      n_fail++; $display("FAIL stray_buffer: got %h required 0", dut.buf_q);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_in_stream();
    logic [255:0] k;
    logic [95:0]  n;
    logic [31:0]  c0;
    logic [31:0]  msg[$];
    int           acc;
    bit           ok;
    bit           saw_fetch;
    k = rand256(); n = rand96(); c0 = $urandom_range(0, 1000);
    for (int i = 0; i < 24; i++) msg.push_back($urandom);
    apply_reset();
    do_start(k, n, c0);
    saw_fetch = 1'b0;
    fork
      drive(msg, 1'b1, 24, 100, acc);
      begin
        for (int i = 0; i < 200 && out_q.size() < 3; i++) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1; key = ~k; nonce = ~n; init_count = c0 + 32'd100;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 200 && !saw_fetch; i++) begin
          @(negedge clk);
          saw_fetch = ks_req;
        end
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_idle(100, ok);
    build_exp(k, n, c0, msg, 24, 1'b1);
    n_checks++;
    if (acc != 24 || !ok || !saw_fetch || out_q.size() != 24) begin
      n_fail++; $display("FAIL sis_flow: got acc=%0d idle=%b fetch=%b outs=%0d required 24 1 1 24",
                         acc, ok, saw_fetch, out_q.size());
    end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL sis_word%0d: got %h required %h", i, out_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (req_log.size() != 2 || req_log[0] !== c0 || req_log[1] !== c0 + 32'd1) begin
      n_fail++; $display("FAIL sis_requests: got %0d requests required %h,%h",
                         req_log.size(), c0, c0 + 32'd1);
    end
    n_checks++;
    if (ks_key !== k || ks_nonce !== n) begin
      n_fail++; $display("FAIL sis_key: got %h required %h", ks_key, k);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; bp_en = 1'b0;
    rst = 1'b0; start = 1'b0; key = '0; nonce = '0; init_count = '0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    stray_v = 1'b0; stray_blk = '0;
    test_reset();
    test_rfc();
    test_round_trip();
    test_backpressure();
    test_counter_limit();
    test_reset_mid_stream();
    test_start_in_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
